// File: rtl/cdc_pkg.sv
// Pointer helpers shared by the async FIFO pointer blocks.
// Gray conversions work on a max-width vector, masked down to the live width.
package cdc_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int unsigned depth_f(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic ptr_max_t width_mask_f(input int unsigned width);
    ptr_max_t m;
    if (width >= PTR_MAX_W) begin
      m = '1;
    end else begin
      m = (ptr_max_t'(1) << width) - ptr_max_t'(1);
    end
    return m;
  endfunction

  function automatic ptr_max_t bin2gray_f(input ptr_max_t bin, input int unsigned width);
    ptr_max_t b;
    b = bin & width_mask_f(width);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR by doubling shifts: bit i ends up as the XOR of all gray bits >= i.
  function automatic ptr_max_t gray2bin_f(input ptr_max_t gray, input int unsigned width);
    ptr_max_t b;
    b = gray & width_mask_f(width);
    for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b & width_mask_f(width);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary to reflected-Gray converter.
module bin2gray #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_bin,
  output logic [DATA_WIDTH-1:0] o_gray
);

  always_comb begin
    o_gray = i_bin ^ (i_bin >> 1);
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic of the async FIFO: binary/Gray write pointer,
// full, almost-full, fill level and sticky overflow against the synchronised read pointer.
module fifo_wptr_full
  import cdc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned AFULL_THRESH = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rq_wptr_gray_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  afull_o,
  output logic [ADDR_WIDTH:0]   wlevel_o,
  output logic                  overflow_o
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] WRAP_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_full;
  logic          r_afull;
  logic [PW-1:0] r_wlevel;
  logic          r_overflow;

  logic          w_push;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_cmp;
  logic [PW-1:0] w_wlevel_next;
  logic          w_full_next;
  logic          w_afull_next;

  bin2gray #(
    .DATA_WIDTH(PW)
  ) u_bin2gray (
    .i_bin (w_wbin_next),
    .o_gray(w_wgray_next)
  );

  // Full when the write pointer leads the read pointer by exactly DEPTH:
  // in Gray that is the read pointer with its top two bits inverted.
  always_comb begin
    w_push        = wr_en_i & ~r_full;
    w_wbin_next   = r_wbin + PW'(w_push);
    w_rbin        = PW'(gray2bin_f(ptr_max_t'(rq_wptr_gray_i), PW));
    w_full_cmp    = rq_wptr_gray_i ^ WRAP_MASK;
    w_full_next   = (w_wgray_next == w_full_cmp);
    w_wlevel_next = w_wbin_next - w_rbin;
    w_afull_next  = (w_wlevel_next >= AFULL_LVL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_wlevel   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_wgray  <= w_wgray_next;
      r_full   <= w_full_next;
      r_afull  <= w_afull_next;
      r_wlevel <= w_wlevel_next;
      if (wr_en_i && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign we_o        = w_push;
  assign waddr_o     = r_wbin[ADDR_WIDTH-1:0];
  assign wptr_gray_o = r_wgray;
  assign full_o      = r_full;
  assign afull_o     = r_afull;
  assign wlevel_o    = r_wlevel;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed and constrained-random checks of the FIFO write-pointer block (ADDR_WIDTH=3).
module tb_fifo_wptr_full;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [3:0] rq_wptr_gray_i;
  logic       we_o;
  logic [2:0] waddr_o;
  logic [3:0] wptr_gray_o;
  logic       full_o;
  logic       afull_o;
  logic [3:0] wlevel_o;
  logic       overflow_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  fifo_wptr_full #(
    .ADDR_WIDTH  (3),
    .AFULL_THRESH(6)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_en_i       (wr_en_i),
    .rq_wptr_gray_i(rq_wptr_gray_i),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .wptr_gray_o   (wptr_gray_o),
    .full_o        (full_o),
    .afull_o       (afull_o),
    .wlevel_o      (wlevel_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gray"},  32'(wptr_gray_o), 32'h0);
    chk({tag, "_waddr"}, 32'(waddr_o),     32'h0);
    chk({tag, "_full"},  32'(full_o),      32'h0);
    chk({tag, "_afull"}, 32'(afull_o),     32'h0);
    chk({tag, "_lvl"},   32'(wlevel_o),    32'h0);
    chk({tag, "_ovf"},   32'(overflow_o),  32'h0);
  endtask

  // Reference model state for the random phase
  logic [3:0] m_wbin, m_rd, m_lvl, m_prev_gray;
  logic       m_full, m_afull, m_ovf, m_push, m_wr;

  initial begin
    rst_i          = 1'b1;
    wr_en_i        = 1'b1;
    rq_wptr_gray_i = 4'b0000;
    tick();
    rst_i   = 1'b0;
    wr_en_i = 1'b0;
    chk_reset_state("reset");

    // Fill 8 entries with the reader parked at 0
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1;
      #1;
      chk("fill_we",    32'(we_o),    32'h1);
      chk("fill_waddr", 32'(waddr_o), 32'(i));
      tick();
      chk("fill_lvl",   32'(wlevel_o),    32'(i + 1));
      chk("fill_afull", 32'(afull_o),     32'((i + 1) >= 6));
      chk("fill_full",  32'(full_o),      32'((i + 1) == 8));
      chk("fill_gray",  32'(wptr_gray_o), 32'(g(4'(i + 1))));
    end
    chk("full8_gray",  32'(wptr_gray_o), 32'b1100);
    chk("full8_waddr", 32'(waddr_o),     32'h0);
    chk("full8_lvl",   32'(wlevel_o),    32'h8);

    // Write while full is dropped and latches overflow
    wr_en_i = 1'b1;
    #1;
    chk("ovf_we", 32'(we_o), 32'h0);
    tick();
    wr_en_i = 1'b0;
    chk("ovf_gray", 32'(wptr_gray_o), 32'b1100);
    chk("ovf_flag", 32'(overflow_o),  32'h1);
    chk("ovf_full", 32'(full_o),      32'h1);
    chk("ovf_lvl",  32'(wlevel_o),    32'h8);

    // Reader advances to 1: space frees up one cycle later
    rq_wptr_gray_i = 4'b0001;
    tick();
    chk("rd1_full",  32'(full_o),     32'h0);
    chk("rd1_lvl",   32'(wlevel_o),   32'h7);
    chk("rd1_afull", 32'(afull_o),    32'h1);
    chk("rd1_ovf",   32'(overflow_o), 32'h1);

    // Reader at 8 (gray 1100): eight more pushes wrap the pointer to 0
    rq_wptr_gray_i = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      wr_en_i = 1'b1;
      #1;
      chk("wrap_we",    32'(we_o),    32'h1);
      chk("wrap_waddr", 32'(waddr_o), 32'(i));
      tick();
      chk("wrap_lvl",  32'(wlevel_o), 32'(i + 1));
      chk("wrap_full", 32'(full_o),   32'((i + 1) == 8));
    end
    wr_en_i = 1'b0;
    chk("wrap_gray", 32'(wptr_gray_o), 32'b0000);
    chk("wrap_ovf",  32'(overflow_o),  32'h1);

    // Random traffic against a reference model; reset dropped in mid-burst
    m_wbin = 4'd0;  m_rd = 4'd8;  m_full = 1'b1;  m_afull = 1'b1;
    m_ovf  = 1'b1;  m_lvl = 4'd8; m_prev_gray = 4'b0000;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc == 100) begin
        rst_i          = 1'b1;
        wr_en_i        = 1'b1;
        rq_wptr_gray_i = 4'b0000;
        tick();
        rst_i   = 1'b0;
        wr_en_i = 1'b0;
        chk_reset_state("midrst");
        m_wbin = '0; m_rd = '0; m_full = 1'b0; m_afull = 1'b0;
        m_ovf  = 1'b0; m_lvl = '0; m_prev_gray = '0;
      end
      m_wr = 1'($urandom_range(0, 99) < 60);
      if (m_wbin != m_rd && $urandom_range(0, 99) < 45) begin
        m_rd = m_rd + 4'd1;
      end
      wr_en_i        = m_wr;
      rq_wptr_gray_i = g(m_rd);
      #1;
      m_push = m_wr & ~m_full;
      chk("rnd_we",    32'(we_o),    32'(m_push));
      chk("rnd_waddr", 32'(waddr_o), 32'(m_wbin[2:0]));
      tick();
      m_ovf   = m_ovf | (m_wr & m_full);
      m_wbin  = m_wbin + 4'(m_push);
      m_lvl   = m_wbin - m_rd;
      m_full  = (m_lvl == 4'd8);
      m_afull = (m_lvl >= 4'd6);
      chk("rnd_gray",  32'(wptr_gray_o), 32'(g(m_wbin)));
      chk("rnd_ham",   32'($countones(wptr_gray_o ^ m_prev_gray)), 32'(m_push));
      chk("rnd_lvl",   32'(wlevel_o),   32'(m_lvl));
      chk("rnd_full",  32'(full_o),     32'(m_full));
      chk("rnd_afull", 32'(afull_o),    32'(m_afull));
      chk("rnd_ovf",   32'(overflow_o), 32'(m_ovf));
      m_prev_gray = g(m_wbin);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
